// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// Registered ALU operands; single tagged valid/ready response port.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int OPW     = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   gnt;
  logic             found;
  logic             take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  // First pass: indices at/after rr_ptr; second pass wraps to the low ones.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*OPW +: OPW];
      end
    end
  end

  assign take = (state == IDLE) && found;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (take) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      id_reg <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (take) begin
      rr_ptr <= (gnt == IDW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
      id_reg <= gnt;
      alu_a  <= sel_a;
      alu_b  <= sel_b;
      alu_op <= sel_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_id    <= id_reg;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: vector table, corner sequences, random vs model.
// A small behavioural ALU drives alu_result from the DUT's registered operands.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] req_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int checks = 0;
  int passes = 0;

  alu_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return ~a;
      4'h3: return ~(a | b);
      4'h4: return a ^ b;
      4'h5: return ~(a ^ b);
      4'h8: return {15'b0, a == b};
      4'h9: return {15'b0, a <= b};
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    #1;
    while (req_ready == 4'b0 && n < 12) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 12) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_op[id*4 +: 4]  = op;
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [15:0] exp);
    @(negedge clk);
    set_req(id, a, b, op);
    req_valid = 4'b1 << id;
    wait_ready("grant");
    chk("grant", req_ready, 4'b1 << id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_id", rsp_id, id);
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int gid[5];
    int gcyc[5];
    int ng;
    int cyc;
    int m_ptr;
    bit out;
    int age;
    int e_id;
    logic [15:0] e_data;
    logic [3:0] e_ready;

    vt[0] = '{1, 16'hF0F0, 16'h0FF0, 4'h4, 16'hFF00};
    vt[1] = '{0, 16'd5,    16'd5,    4'h9, 16'h0001};
    vt[2] = '{2, 16'd6,    16'd5,    4'h9, 16'h0000};
    vt[3] = '{3, 16'h1234, 16'hFF00, 4'h0, 16'h1200};
    vt[4] = '{0, 16'h00F0, 16'h0F00, 4'h1, 16'h0FF0};
    vt[5] = '{2, 16'h5555, 16'h5555, 4'h8, 16'h0001};
    vt[6] = '{3, 16'hAAAA, 16'h0000, 4'h2, 16'h5555};
    vt[7] = '{1, 16'd4,    16'd5,    4'h9, 16'h0001};
    vt[8] = '{2, 16'h0001, 16'h0002, 4'hF, 16'hDEAD};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;

    // Backpressure, then asynchronous reset while holding a response
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 16'h00FF, 16'h0F0F, 4'h4);
    req_valid = 4'b0100;
    wait_ready("bp_grant");
    chk("bp_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("bp_rsp_valid", rsp_valid, 1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_data", rsp_data, 16'h0FF0);
      chk("bp_id", rsp_id, 2);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_op", alu_op, 0);
    chk("arst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Round robin with everyone requesting
    ng = 0; cyc = 0;
    #1;
    while (ng < 5 && cyc < 40) begin
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid[ng] = i;
        gcyc[ng] = cyc;
        ng++;
      end
      @(negedge clk); #1; cyc++;
    end
    chk("rr_count", ng, 5);
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", gid[k], k % 4);
      if (k > 0) chk("rr_interval", gcyc[k] - gcyc[k-1], 3);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);

    foreach (vt[i]) issue(vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].exp);

    // Pointer skip: ptr lands on 2, only 0 and 3 request
    issue(1, 16'h0F0F, 16'h00FF, 4'h0, 16'h000F);
    @(negedge clk);
    set_req(0, 16'h1111, 16'h2222, 4'h1);
    set_req(3, 16'h3333, 16'h1111, 4'h4);
    req_valid = 4'b1001;
    wait_ready("skip3");
    chk("skip_first", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_ready("skip0");
    chk("skip_second", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("skip_rsp_id", rsp_id, 0);
    chk("skip_rsp_data", rsp_data, 16'h3333);
    @(negedge clk);
    req_valid = 4'b1111;
    wait_ready("wrap");
    chk("wrap_to_1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Random traffic against a transaction-level model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; out = 0; age = 0; e_id = 0; e_data = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++)
        set_req(i, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 9)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_busy", busy, out);
      if (out) begin
        age++;
        chk("rnd_ready_busy", req_ready, 0);
        if (age == 1) begin
          chk("rnd_exec_valid", rsp_valid, 0);
        end else begin
          chk("rnd_rsp_valid", rsp_valid, 1);
          chk("rnd_rsp_data", rsp_data, e_data);
          chk("rnd_rsp_id", rsp_id, e_id);
          if (rsp_ready) out = 0;
        end
      end else begin
        e_ready = '0;
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (e_ready == 4'b0 && req_valid[j]) begin
            e_ready = 4'b1 << j;
            e_id = j;
          end
        end
        chk("rnd_ready", req_ready, e_ready);
        chk("rnd_idle_valid", rsp_valid, 0);
        if (e_ready != 4'b0) begin
          out = 1; age = 0;
          e_data = alu_f(req_a[e_id*16 +: 16], req_b[e_id*16 +: 16], req_op[e_id*4 +: 4]);
          m_ptr = (e_id + 1) % 4;
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
